// File: rtl/sw_ingress.sv
// -----------------------------------------------------------------------------
// sw_ingress -- switch ingress stage.
//
// Parses a packet stream of the form  header, length L, L payload words
// and forwards it to one of NUM_OF_PORTS downstream FIFOs. The header is the
// destination port index. Packets with an out-of-range header are consumed
// and discarded. Data is a zero-latency pass-through. The per-port rd_in bit
// back-pressures the source through in_ready.
//
// Optional feature (macro SW_INGRESS_PARITY_EN):
//   Each packet carries one trailing parity word. It is forwarded like payload.
//   After it is transferred, the XOR of header, length, payload and parity is
//   checked. If the XOR is nonzero, pkt_err pulses for one cycle.
//   Without the macro there is no parity word and pkt_err is tied to 0.
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   in_data     packet word from the source
//   in_valid    in_data is valid
//   in_ready    word is accepted this cycle (transfer = in_valid & in_ready)
//   rd_in       per-port "FIFO not full"
//   sw_en       write strobe for the port selected by port_addr
//   port_data   word broadcast to all ports (equals in_data)
//   port_addr   destination of the current packet
//   pkt_cnt     forwarded packets, saturating at 16'hFFFF
//   drop_cnt    dropped packets, saturating at 16'hFFFF
//   pkt_err     one-cycle parity error pulse
// -----------------------------------------------------------------------------
module sw_ingress #(
    parameter int NUM_OF_PORTS = 4,
    parameter int W_WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_WIDTH-1:0]      in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_OF_PORTS-1:0] rd_in,
    output logic                    sw_en,
    output logic [W_WIDTH-1:0]      port_data,
    output logic [W_WIDTH-1:0]      port_addr,
    output logic [15:0]             pkt_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    pkt_err
);
    localparam int IDX_W = $clog2(NUM_OF_PORTS);
    // One extra bit so that a dropped packet of maximum length plus its
    // trailing parity word still fits in the remaining-word counter.
    localparam int REM_W = W_WIDTH + 1;
`ifdef SW_INGRESS_PARITY_EN
    localparam logic [REM_W-1:0] TRAIL_WORDS = REM_W'(1);
`else
    localparam logic [REM_W-1:0] TRAIL_WORDS = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_DROP_LEN,
        S_DROP
`ifdef SW_INGRESS_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t             state_reg, state_next;
    logic [W_WIDTH-1:0] addr_reg, addr_next;
    logic [REM_W-1:0]   rem_reg, rem_next;
    logic [REM_W-1:0]   drop_len;
    logic [15:0]        pkt_cnt_reg, drop_cnt_reg;
    logic               pkt_inc, drop_inc;
    logic               hdr_ok, ready_c, xfer, sw_en_c;
    logic [IDX_W-1:0]   hdr_idx, cur_idx;

    assign hdr_idx  = in_data[IDX_W-1:0];
    assign cur_idx  = addr_reg[IDX_W-1:0];
    assign hdr_ok   = in_data < W_WIDTH'(NUM_OF_PORTS);
    assign drop_len = {1'b0, in_data} + TRAIL_WORDS;

    // The ready decode is kept separate from the next-state logic. The
    // transfer term derived from it then feeds the FSM without a
    // combinational loop inside one process.
    always_comb begin
        ready_c = 1'b0;
        case (state_reg)
            S_IDLE:     ready_c = hdr_ok ? rd_in[hdr_idx] : 1'b1;
            S_LEN:      ready_c = rd_in[cur_idx];
            S_PAYLOAD:  ready_c = rd_in[cur_idx];
`ifdef SW_INGRESS_PARITY_EN
            S_PARITY:   ready_c = rd_in[cur_idx];
`endif
            S_DROP_LEN: ready_c = 1'b1;
            S_DROP:     ready_c = 1'b1;
            default:    ready_c = 1'b0;
        endcase
    end

    assign in_ready = ready_c & ~rst;
    assign xfer     = in_valid & in_ready;

`ifdef SW_INGRESS_PARITY_EN
    logic [W_WIDTH-1:0] par_reg, par_next;
    logic               err_reg, err_next;
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rem_next   = rem_reg;
        sw_en_c    = 1'b0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
`ifdef SW_INGRESS_PARITY_EN
        par_next   = par_reg;
        err_next   = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        sw_en_c    = 1'b1;
                        addr_next  = in_data;
                        state_next = S_LEN;
`ifdef SW_INGRESS_PARITY_EN
                        par_next   = in_data;
`endif
                    end else begin
                        drop_inc   = 1'b1;
                        state_next = S_DROP_LEN;
                    end
                end
            end
            S_LEN, S_PAYLOAD: begin
                if (xfer) begin
                    sw_en_c = 1'b1;
`ifdef SW_INGRESS_PARITY_EN
                    par_next = par_reg ^ in_data;
`endif
                    if (state_reg == S_LEN)
                        rem_next = {1'b0, in_data};
                    else
                        rem_next = rem_reg - REM_W'(1);
                    // Last payload word, or a zero-length packet on the length word.
                    if ((state_reg == S_LEN && in_data == '0) ||
                        (state_reg == S_PAYLOAD && rem_reg == REM_W'(1))) begin
`ifdef SW_INGRESS_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_IDLE;
                        pkt_inc    = 1'b1;
`endif
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
`ifdef SW_INGRESS_PARITY_EN
            S_PARITY: begin
                if (xfer) begin
                    sw_en_c    = 1'b1;
                    err_next   = (par_reg ^ in_data) != '0;
                    pkt_inc    = 1'b1;
                    state_next = S_IDLE;
                end
            end
`endif
            S_DROP_LEN: begin
                if (xfer) begin
                    rem_next   = drop_len;
                    state_next = (drop_len == '0) ? S_IDLE : S_DROP;
                end
            end
            S_DROP: begin
                if (xfer) begin
                    rem_next = rem_reg - REM_W'(1);
                    if (rem_reg == REM_W'(1))
                        state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            rem_reg      <= '0;
            pkt_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rem_reg   <= rem_next;
            if (pkt_inc && pkt_cnt_reg != 16'hFFFF)
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            if (drop_inc && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

`ifdef SW_INGRESS_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            par_reg <= par_next;
            err_reg <= err_next;
        end
    end
    assign pkt_err = err_reg;
`else
    assign pkt_err = 1'b0;
`endif

    assign sw_en     = sw_en_c;
    assign port_data = in_data;
    // The header cycle shows the incoming header directly, so the
    // downstream port sees its address in the same cycle as sw_en.
    assign port_addr = (state_reg == S_IDLE && in_valid && !rst) ? in_data : addr_reg;
    assign pkt_cnt   = pkt_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_sw_ingress.sv
`timescale 1ns/1ps
module tb_sw_ingress;
    localparam int NP = 4;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NP-1:0] rd_in;
    logic          sw_en;
    logic [W-1:0]  port_data;
    logic [W-1:0]  port_addr;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;
    logic          pkt_err;

    sw_ingress #(.NUM_OF_PORTS(NP), .W_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd_in(rd_in), .sw_en(sw_en),
        .port_data(port_data), .port_addr(port_addr), .pkt_cnt(pkt_cnt),
        .drop_cnt(drop_cnt), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    // Reference model: the packet stream is a list of words. Each word is
    // tagged with its role, which is derived from the packet format.
    typedef struct {
        logic [7:0] d;
        bit         fwd;       // word goes to a downstream port
        int         dest;      // destination port when fwd
        bit         drop_hdr;  // header of a dropped packet
        bit         last;      // final word of a forwarded packet
        bit         bad;       // parity word carrying an error
    } word_t;

    word_t stream[$];
    int    idx;
    int    exp_pkt, exp_drop;
    bit    err_pend;
    int    nvec, nmis;

    function automatic void push_w(input logic [7:0] d, input bit fwd, input int dest,
                                   input bit drop_hdr);
        word_t w;
        w.d = d; w.fwd = fwd; w.dest = dest; w.drop_hdr = drop_hdr;
        w.last = 1'b0; w.bad = 1'b0;
        stream.push_back(w);
    endfunction

    // Queue one packet. Payload word i is base + i*step. flip corrupts
    // the parity word when the parity feature is built in.
    task automatic add_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base,
                           input logic [7:0] step, input logic [7:0] flip);
        bit         ok;
        int         dest;
        logic [7:0] x, d;
        word_t      t;
        ok   = (hdr < NP);
        dest = ok ? int'(hdr) : 0;
        x    = hdr;
        push_w(hdr, ok, dest, !ok);
        push_w(8'(len), ok, dest, 1'b0);
        x ^= 8'(len);
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i) * step;
            x ^= d;
            push_w(d, ok, dest, 1'b0);
        end
`ifdef SW_INGRESS_PARITY_EN
        push_w(x ^ flip, ok, dest, 1'b0);
`endif
        t = stream.pop_back();
        t.last = ok;
`ifdef SW_INGRESS_PARITY_EN
        t.bad = ok && (flip != 8'h00);
`endif
        stream.push_back(t);
        $display("pkt queued: hdr=%02h len=%0d flip=%02h %s", hdr, len, flip,
                 ok ? "forward" : "drop");
    endtask

    // Plays the stream from idx up to stop_at, one cycle per iteration.
    // All outputs are checked at the negedge against the model.
    task automatic run_stream(input int vprob, input int rprob, input int stop_at,
                              input int stall_at, input int stall_len);
        int    cyc, stall;
        bit    exp_rdy, exp_sw, xfer;
        word_t w;
        cyc   = 0;
        stall = stall_len;
        while (idx < stop_at && cyc < 20000) begin
            w        = stream[idx];
            in_valid = ($urandom_range(0, 99) < vprob);
            for (int b = 0; b < NP; b++) rd_in[b] = ($urandom_range(0, 99) < rprob);
            if (idx == stall_at && stall > 0) begin
                in_valid      = 1'b1;
                rd_in[w.dest] = 1'b0;
                stall--;
            end
            in_data = in_valid ? w.d : 8'($urandom);
            @(negedge clk);
            exp_rdy = w.fwd ? rd_in[w.dest] : 1'b1;
            exp_sw  = in_valid && w.fwd && exp_rdy;
            if (in_valid) begin
                nvec++;
                if (in_ready !== exp_rdy) begin
                    nmis++;
                    $display("FAIL in_ready word %0d: got %b expected %b", idx, in_ready, exp_rdy);
                end
            end
            nvec++;
            if (sw_en !== exp_sw) begin
                nmis++;
                $display("FAIL sw_en word %0d: got %b expected %b", idx, sw_en, exp_sw);
            end
            if (exp_sw) begin
                nvec++;
                if (port_data !== w.d) begin
                    nmis++;
                    $display("FAIL port_data word %0d: got %02h expected %02h", idx, port_data, w.d);
                end
                nvec++;
                if (port_addr !== 8'(w.dest)) begin
                    nmis++;
                    $display("FAIL port_addr word %0d: got %02h expected %02h", idx, port_addr, 8'(w.dest));
                end
            end
            nvec++;
            if (pkt_cnt !== 16'(exp_pkt)) begin
                nmis++;
                $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, exp_pkt);
            end
            nvec++;
            if (drop_cnt !== 16'(exp_drop)) begin
                nmis++;
                $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, exp_drop);
            end
            nvec++;
            if (pkt_err !== err_pend) begin
                nmis++;
                $display("FAIL pkt_err: got %b expected %b", pkt_err, err_pend);
            end
            xfer = in_valid && exp_rdy;
            @(posedge clk);
            #1;
            err_pend = xfer && w.bad;
            if (xfer) begin
                if (w.last && exp_pkt < 65535)  exp_pkt++;
                if (w.drop_hdr && exp_drop < 65535) exp_drop++;
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        nvec++;
        if (idx < stop_at) begin
            nmis++;
            $display("FAIL stream_timeout: reached word %0d expected %0d", idx, stop_at);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        nvec++;
        if (in_ready !== 1'b0) begin nmis++; $display("FAIL %s in_ready: got %b expected 0", tag, in_ready); end
        nvec++;
        if (sw_en !== 1'b0) begin nmis++; $display("FAIL %s sw_en: got %b expected 0", tag, sw_en); end
        nvec++;
        if (port_addr !== 8'h00) begin nmis++; $display("FAIL %s port_addr: got %02h expected 00", tag, port_addr); end
        nvec++;
        if (pkt_cnt !== 16'h0) begin nmis++; $display("FAIL %s pkt_cnt: got %0d expected 0", tag, pkt_cnt); end
        nvec++;
        if (drop_cnt !== 16'h0) begin nmis++; $display("FAIL %s drop_cnt: got %0d expected 0", tag, drop_cnt); end
        nvec++;
        if (pkt_err !== 1'b0) begin nmis++; $display("FAIL %s pkt_err: got %b expected 0", tag, pkt_err); end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        rd_in    = '1;
        #1;
        check_reset_outputs("reset_async");
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        $display("reset: checked");
    endtask

    task automatic test_forward();
        add_pkt(8'h02, 3, 8'hA1, 8'h01, 8'h00);
        run_stream(100, 100, stream.size(), -1, 0);
    endtask

    task automatic test_drop();
        add_pkt(8'h07, 2, 8'h11, 8'h11, 8'h00);
        run_stream(100, 100, stream.size(), -1, 0);
    endtask

    task automatic test_stall();
        int base;
        base = idx;
        add_pkt(8'h01, 4, 8'h30, 8'h01, 8'h00);
        run_stream(100, 100, stream.size(), base + 4, 3);
    endtask

    task automatic test_back_to_back();
        add_pkt(8'h00, 0, 8'h00, 8'h00, 8'h00);
        add_pkt(8'h03, 1, 8'h55, 8'h00, 8'h00);
        run_stream(100, 100, stream.size(), -1, 0);
    endtask

`ifdef SW_INGRESS_PARITY_EN
    task automatic test_parity();
        add_pkt(8'h01, 1, 8'h10, 8'h00, 8'h10);
        add_pkt(8'h01, 1, 8'h10, 8'h00, 8'h00);
        run_stream(100, 100, stream.size(), -1, 0);
    endtask
`endif

    task automatic test_random();
        logic [7:0] flip;
        for (int p = 0; p < 40; p++) begin
            flip = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 255)) : 8'h00;
            add_pkt(8'($urandom_range(0, 7)), $urandom_range(0, 6), 8'($urandom),
                    8'($urandom), flip);
        end
        add_pkt(8'h03, 255, 8'h00, 8'h03, 8'h00);
        add_pkt(8'h09, 255, 8'h00, 8'h05, 8'h00);
        run_stream(70, 75, stream.size(), -1, 0);
    endtask

    task automatic test_reset_mid();
        add_pkt(8'h01, 5, 8'h60, 8'h01, 8'h00);
        run_stream(100, 100, idx + 4, -1, 0);
        in_valid = 1'b1;
        in_data  = stream[idx].d;
        rd_in    = '1;
        rst      = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        stream.delete();
        idx      = 0;
        exp_pkt  = 0;
        exp_drop = 0;
        err_pend = 1'b0;
        add_pkt(8'h02, 2, 8'h70, 8'h01, 8'h00);
        add_pkt(8'h05, 1, 8'h80, 8'h01, 8'h00);
        run_stream(100, 100, stream.size(), -1, 0);
    endtask

    initial begin
        nvec = 0; nmis = 0; idx = 0; exp_pkt = 0; exp_drop = 0; err_pend = 1'b0;
        test_reset();
        test_forward();
        test_drop();
        test_stall();
        test_back_to_back();
`ifdef SW_INGRESS_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at word %0d", idx);
        $fatal(1, "watchdog");
    end

endmodule
